// File: rtl/sc_count_collect_pkg.sv
// Shared constants and the result-buffer state type for stochastic-computing count collection.
package sc_count_collect_pkg;
  localparam int SC_CNT_WIDTH = 16;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } out_state_e;
endpackage

// File: rtl/sc_count_collect_sat_ctr.sv
// Saturating up-counter; exposes the post-increment value so a frame can be
// captured including the bit arriving on its final cycle.
module sat_ctr #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] cnt_nxt,
  output logic         sat_hit
);
  logic [W-1:0] cnt;
  logic         at_max;

  assign at_max  = &cnt;
  assign sat_hit = en && at_max;
  assign cnt_nxt = (en && !at_max) ? cnt + W'(1) : cnt;

  always_ff @(posedge clk) begin
    if (rst || clr) cnt <= '0;
    else            cnt <= cnt_nxt;
  end
endmodule

// File: rtl/sc_count_collect.sv
// Counts ones per SC stream over a frame and double-buffers the result so
// upstream never stalls; a late consumer gets overwritten and overrun latches.
module sc_count_collect
  import sc_count_collect_pkg::*;
#(
  parameter int NUM_INPUTS = 8,
  parameter int CNT_WIDTH  = SC_CNT_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  input  logic [NUM_INPUTS-1:0] in_bits,
  input  logic                  in_last,
  input  logic                  abort,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [CNT_WIDTH-1:0]  out_cnts [NUM_INPUTS],
  output logic [CNT_WIDTH-1:0]  out_len,
  output logic                  out_sat,
  output logic                  overrun
);
  logic                 take, done, acc_clr;
  logic                 acc_sat, acc_sat_nxt;
  logic [NUM_INPUTS:0]  hit;
  logic [CNT_WIDTH-1:0] cnt_nxt [NUM_INPUTS+1];
  out_state_e           state;

  assign take        = in_valid && !abort;
  assign done        = take && in_last;
  assign acc_clr     = abort || done;
  assign acc_sat_nxt = acc_sat || (|hit);

  // Slot NUM_INPUTS is the frame-length counter; it ticks on every taken cycle.
  for (genvar i = 0; i <= NUM_INPUTS; i++) begin : g_ctr
    logic en;
    if (i < NUM_INPUTS) begin : g_bit
      assign en = take && in_bits[i];
    end else begin : g_len
      assign en = take;
    end
    sat_ctr #(.W(CNT_WIDTH)) u_ctr (
      .clk     (clk),
      .rst     (rst),
      .clr     (acc_clr),
      .en      (en),
      .cnt_nxt (cnt_nxt[i]),
      .sat_hit (hit[i])
    );
  end

  always_ff @(posedge clk) begin
    if (rst || acc_clr) acc_sat <= 1'b0;
    else                acc_sat <= acc_sat_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_EMPTY;
      out_valid <= 1'b0;
      overrun   <= 1'b0;
      out_len   <= '0;
      out_sat   <= 1'b0;
      for (int i = 0; i < NUM_INPUTS; i++) out_cnts[i] <= '0;
    end else if (done) begin
      for (int i = 0; i < NUM_INPUTS; i++) out_cnts[i] <= cnt_nxt[i];
      out_len   <= cnt_nxt[NUM_INPUTS];
      out_sat   <= acc_sat_nxt;
      state     <= ST_FULL;
      out_valid <= 1'b1;
      if (state == ST_FULL && !out_ready) overrun <= 1'b1;
    end else if (state == ST_FULL && out_ready) begin
      state     <= ST_EMPTY;
      out_valid <= 1'b0;
    end
  end
endmodule
